// File: rtl/bus_rv32_timer_pkg.sv
// Shared register offsets, CTRL bit layout and decode helper for the rv32 bus timer.
package bus_rv32_timer_pkg;

  localparam logic [4:0] TMR_CTRL     = 5'h00;
  localparam logic [4:0] TMR_PRESCALE = 5'h04;
  localparam logic [4:0] TMR_COMPARE  = 5'h08;
  localparam logic [4:0] TMR_COUNT    = 5'h0C;
  localparam logic [4:0] TMR_STATUS   = 5'h10;

  localparam int CTRL_EN   = 0;
  localparam int CTRL_AUTO = 1;
  localparam int CTRL_IE   = 2;

  typedef struct packed {
    logic ie;
    logic auto_reload;
    logic en;
  } tmr_ctrl_t;

  function automatic logic is_tmr_offset(input logic [4:0] off);
    return (off == TMR_CTRL) || (off == TMR_PRESCALE) || (off == TMR_COMPARE) ||
           (off == TMR_COUNT) || (off == TMR_STATUS);
  endfunction

endpackage

// File: rtl/bus_rv32_timer_prescaler.sv
// Prescaler: counts 0..prescale while enabled and pulses tick on the terminal count.
module bus_rv32_timer_prescaler #(
  parameter int PRESCALE_WIDTH = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      en,
  input  logic                      clear,
  input  logic [PRESCALE_WIDTH-1:0] prescale,
  output logic                      tick
);

  logic [PRESCALE_WIDTH-1:0] pre;

  assign tick = en && (pre == prescale);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pre <= '0;
    end else if (!en || clear || tick) begin
      pre <= '0;
    end else begin
      pre <= pre + PRESCALE_WIDTH'(1);
    end
  end

endmodule

// File: rtl/bus_rv32_timer_responder.sv
// Memory-mapped compare timer on the rv32 CPU bus: register file, counter,
// match/irq logic and one-cycle registered read path.
module bus_rv32_timer_responder
  import bus_rv32_timer_pkg::*;
#(
  parameter int                       ADDRESS_WIDTH  = 32,
  parameter int                       DATA_WIDTH     = 32,
  parameter logic [ADDRESS_WIDTH-1:0] BASE_ADDR      = 32'h0000_9000,
  parameter int                       PRESCALE_WIDTH = 16
) (
  input  logic                     clk_i,
  input  logic                     reset_i,
  input  logic [ADDRESS_WIDTH-1:0] address_i,
  input  logic                     we_i,
  input  logic [DATA_WIDTH-1:0]    wdata_i,
  output logic [DATA_WIDTH-1:0]    rdata_o,
  output logic                     hit_o,
  output logic                     irq_o
);

  tmr_ctrl_t                 ctrl;
  logic [PRESCALE_WIDTH-1:0] prescale;
  logic [DATA_WIDTH-1:0]     compare;
  logic [DATA_WIDTH-1:0]     count;
  logic                      match;

  logic [4:0]            offset;
  logic                  hit;
  logic                  wr_ctrl, wr_prescale, wr_compare, wr_count, wr_status;
  logic                  tick;
  logic                  pre_clear;
  logic                  match_evt;
  logic [DATA_WIDTH-1:0] rd_mux;

  assign offset = address_i[4:0];
  assign hit    = (address_i[ADDRESS_WIDTH-1:5] == BASE_ADDR[ADDRESS_WIDTH-1:5]) &&
                  is_tmr_offset(offset);

  assign wr_ctrl     = we_i && hit && (offset == TMR_CTRL);
  assign wr_prescale = we_i && hit && (offset == TMR_PRESCALE);
  assign wr_compare  = we_i && hit && (offset == TMR_COMPARE);
  assign wr_count    = we_i && hit && (offset == TMR_COUNT);
  assign wr_status   = we_i && hit && (offset == TMR_STATUS);

  // A CPU load of COUNT pre-empts the tick, so no match is evaluated that edge.
  assign match_evt = tick && (count == compare) && !wr_count;
  assign pre_clear = wr_count || (wr_ctrl && wdata_i[CTRL_EN] && !ctrl.en);

  bus_rv32_timer_prescaler #(
    .PRESCALE_WIDTH(PRESCALE_WIDTH)
  ) u_prescaler (
    .clk     (clk_i),
    .rst     (reset_i),
    .en      (ctrl.en),
    .clear   (pre_clear),
    .prescale(prescale),
    .tick    (tick)
  );

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      ctrl     <= '0;
      prescale <= '0;
      compare  <= '0;
    end else begin
      if (wr_ctrl) begin
        ctrl <= '{ie: wdata_i[CTRL_IE], auto_reload: wdata_i[CTRL_AUTO], en: wdata_i[CTRL_EN]};
      end else if (match_evt && !ctrl.auto_reload) begin
        ctrl.en <= 1'b0;
      end
      if (wr_prescale) prescale <= wdata_i[PRESCALE_WIDTH-1:0];
      if (wr_compare)  compare  <= wdata_i;
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      count <= '0;
      match <= 1'b0;
    end else begin
      if (wr_count) begin
        count <= wdata_i;
      end else if (match_evt) begin
        if (ctrl.auto_reload) count <= '0;
      end else if (tick) begin
        count <= count + DATA_WIDTH'(1);
      end
      // Set has priority over a same-edge W1C.
      if (match_evt) begin
        match <= 1'b1;
      end else if (wr_status && wdata_i[0]) begin
        match <= 1'b0;
      end
    end
  end

  always_comb begin
    rd_mux = '0;
    if (hit && !we_i) begin
      case (offset)
        TMR_CTRL:     rd_mux = DATA_WIDTH'(ctrl);
        TMR_PRESCALE: rd_mux = DATA_WIDTH'(prescale);
        TMR_COMPARE:  rd_mux = compare;
        TMR_COUNT:    rd_mux = count;
        TMR_STATUS:   rd_mux = DATA_WIDTH'(match);
        default:      rd_mux = '0;
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      rdata_o <= '0;
      hit_o   <= 1'b0;
      irq_o   <= 1'b0;
    end else begin
      rdata_o <= rd_mux;
      hit_o   <= hit;
      irq_o   <= match & ctrl.ie;
    end
  end

endmodule

// File: tb/tb_bus_rv32_timer_responder.sv
// Scoreboard bench for bus_rv32_timer_responder: expected read results are queued
// as each read is issued and compared when the registered response appears.
module tb_bus_rv32_timer_responder;
  import bus_rv32_timer_pkg::*;

  localparam logic [31:0] BASE = 32'h0000_9000;

  logic        clk = 1'b0;
  logic        reset_i = 1'b1;
  logic [31:0] address_i = 32'h0;
  logic        we_i = 1'b0;
  logic [31:0] wdata_i = 32'h0;
  logic [31:0] rdata_o;
  logic        hit_o;
  logic        irq_o;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] rdata;
    logic        hit;
    string       name;
  } exp_t;

  exp_t sb[$];
  exp_t e;

  bus_rv32_timer_responder #(
    .ADDRESS_WIDTH (32),
    .DATA_WIDTH    (32),
    .BASE_ADDR     (32'h0000_9000),
    .PRESCALE_WIDTH(16)
  ) dut (
    .clk_i    (clk),
    .reset_i  (reset_i),
    .address_i(address_i),
    .we_i     (we_i),
    .wdata_i  (wdata_i),
    .rdata_o  (rdata_o),
    .hit_o    (hit_o),
    .irq_o    (irq_o)
  );

  always #5 clk = ~clk;

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic bus_write(input logic [4:0] off, input logic [31:0] d);
    address_i = BASE | 32'(off);
    we_i      = 1'b1;
    wdata_i   = d;
    step(1);
    we_i      = 1'b0;
    address_i = 32'h0;
    wdata_i   = 32'h0;
  endtask

  task automatic bus_read(input logic [4:0] off);
    address_i = BASE | 32'(off);
    we_i      = 1'b0;
    step(1);
    address_i = 32'h0;
  endtask

  task automatic test_reset();
    logic [4:0] offs [6] = '{TMR_CTRL, TMR_PRESCALE, TMR_COMPARE, TMR_COUNT, TMR_STATUS, 5'h14};
    #2;
    checks++;
    if (rdata_o !== 32'h0 || hit_o !== 1'b0 || irq_o !== 1'b0) begin
      errors++;
      $display("FAIL rst_outputs: rdata=%h hit=%b irq=%b expected 0/0/0", rdata_o, hit_o, irq_o);
    end
    step(2);
    reset_i = 1'b0;
    for (int i = 0; i < 6; i++) begin
      sb.push_back('{32'h0, (i < 5), $sformatf("rst_rd_off%0h", offs[i])});
      bus_read(offs[i]);
      e = sb.pop_front();
      checks++;
      if (rdata_o !== e.rdata || hit_o !== e.hit) begin
        errors++;
        $display("FAIL %s: rdata=%h hit=%b expected rdata=%h hit=%b", e.name, rdata_o, hit_o, e.rdata, e.hit);
      end
    end
    checks++;
    if (irq_o !== 1'b0) begin
      errors++;
      $display("FAIL rst_irq: irq=%b expected 0", irq_o);
    end
  endtask

  task automatic test_periodic();
    bus_write(TMR_PRESCALE, 32'h0);
    bus_write(TMR_COMPARE, 32'h3);
    bus_write(TMR_CTRL, 32'h7);
    for (int i = 0; i < 5; i++) begin
      sb.push_back('{(i == 4) ? 32'h0 : 32'(i), 1'b1, $sformatf("per_count%0d", i)});
      bus_read(TMR_COUNT);
      e = sb.pop_front();
      checks++;
      if (rdata_o !== e.rdata || hit_o !== e.hit) begin
        errors++;
        $display("FAIL %s: rdata=%h hit=%b expected rdata=%h hit=%b", e.name, rdata_o, hit_o, e.rdata, e.hit);
      end
      checks++;
      if (irq_o !== (i == 4)) begin
        errors++;
        $display("FAIL per_irq%0d: irq=%b expected %b", i, irq_o, (i == 4));
      end
    end
    sb.push_back('{32'h1, 1'b1, "per_status"});
    bus_read(TMR_STATUS);
    e = sb.pop_front();
    checks++;
    if (rdata_o !== e.rdata || hit_o !== e.hit) begin
      errors++;
      $display("FAIL %s: rdata=%h hit=%b expected rdata=%h hit=%b", e.name, rdata_o, hit_o, e.rdata, e.hit);
    end
    bus_write(TMR_CTRL, 32'h4);
    bus_write(TMR_STATUS, 32'h1);
    checks++;
    if (irq_o !== 1'b1) begin
      errors++;
      $display("FAIL per_irq_w1c_edge: irq=%b expected 1", irq_o);
    end
    step(1);
    checks++;
    if (irq_o !== 1'b0) begin
      errors++;
      $display("FAIL per_irq_w1c_after: irq=%b expected 0", irq_o);
    end
    sb.push_back('{32'h3, 1'b1, "per_count_stopped"});
    bus_read(TMR_COUNT);
    e = sb.pop_front();
    checks++;
    if (rdata_o !== e.rdata || hit_o !== e.hit) begin
      errors++;
      $display("FAIL %s: rdata=%h hit=%b expected rdata=%h hit=%b", e.name, rdata_o, hit_o, e.rdata, e.hit);
    end
  endtask

  task automatic test_oneshot();
    logic [4:0]  offs [6] = '{TMR_STATUS, TMR_STATUS, TMR_CTRL, TMR_COUNT, TMR_COUNT, TMR_CTRL};
    logic [31:0] vals [6] = '{32'h0, 32'h1, 32'h4, 32'h2, 32'h2, 32'h4};
    bus_write(TMR_COUNT, 32'h0);
    bus_write(TMR_PRESCALE, 32'h4);
    bus_write(TMR_COMPARE, 32'h2);
    bus_write(TMR_CTRL, 32'h5);
    step(14);
    for (int i = 0; i < 6; i++) begin
      if (i == 4) step(12);
      sb.push_back('{vals[i], 1'b1, $sformatf("oneshot_rd%0d", i)});
      bus_read(offs[i]);
      e = sb.pop_front();
      checks++;
      if (rdata_o !== e.rdata || hit_o !== e.hit) begin
        errors++;
        $display("FAIL %s: rdata=%h hit=%b expected rdata=%h hit=%b", e.name, rdata_o, hit_o, e.rdata, e.hit);
      end
      if (i < 2) begin
        checks++;
        if (irq_o !== (i == 1)) begin
          errors++;
          $display("FAIL oneshot_irq%0d: irq=%b expected %b", i, irq_o, (i == 1));
        end
      end
    end
    bus_write(TMR_STATUS, 32'h1);
    bus_write(TMR_CTRL, 32'h0);
  endtask

  task automatic test_wrap();
    logic [4:0]  offs [5] = '{TMR_COUNT, TMR_COUNT, TMR_STATUS, TMR_STATUS, TMR_COUNT};
    logic [31:0] vals [5] = '{32'hFFFF_FFFF, 32'h0, 32'h0, 32'h1, 32'h1};
    bus_write(TMR_COUNT, 32'hFFFF_FFFF);
    bus_write(TMR_COMPARE, 32'h5);
    bus_write(TMR_PRESCALE, 32'h0);
    bus_write(TMR_CTRL, 32'h3);
    for (int i = 0; i < 5; i++) begin
      if (i == 2) step(4);
      sb.push_back('{vals[i], 1'b1, $sformatf("wrap_rd%0d", i)});
      bus_read(offs[i]);
      e = sb.pop_front();
      checks++;
      if (rdata_o !== e.rdata || hit_o !== e.hit) begin
        errors++;
        $display("FAIL %s: rdata=%h hit=%b expected rdata=%h hit=%b", e.name, rdata_o, hit_o, e.rdata, e.hit);
      end
    end
    checks++;
    if (irq_o !== 1'b0) begin
      errors++;
      $display("FAIL wrap_irq_masked: irq=%b expected 0", irq_o);
    end
  endtask

  task automatic test_simultaneous();
    bus_write(TMR_CTRL, 32'h0);
    bus_write(TMR_STATUS, 32'h1);
    bus_write(TMR_COMPARE, 32'h3);
    bus_write(TMR_COUNT, 32'h0);
    bus_write(TMR_CTRL, 32'h3);
    step(3);
    bus_write(TMR_STATUS, 32'h1);
    sb.push_back('{32'h1, 1'b1, "sim_set_beats_w1c"});
    bus_read(TMR_STATUS);
    e = sb.pop_front();
    checks++;
    if (rdata_o !== e.rdata || hit_o !== e.hit) begin
      errors++;
      $display("FAIL %s: rdata=%h hit=%b expected rdata=%h hit=%b", e.name, rdata_o, hit_o, e.rdata, e.hit);
    end
    bus_write(TMR_STATUS, 32'h1);
    step(1);
    bus_write(TMR_COUNT, 32'h7);
    sb.push_back('{32'h7, 1'b1, "sim_count_write_wins"});
    sb.push_back('{32'h0, 1'b1, "sim_no_match"});
    bus_read(TMR_COUNT);
    e = sb.pop_front();
    checks++;
    if (rdata_o !== e.rdata || hit_o !== e.hit) begin
      errors++;
      $display("FAIL %s: rdata=%h hit=%b expected rdata=%h hit=%b", e.name, rdata_o, hit_o, e.rdata, e.hit);
    end
    bus_read(TMR_STATUS);
    e = sb.pop_front();
    checks++;
    if (rdata_o !== e.rdata || hit_o !== e.hit) begin
      errors++;
      $display("FAIL %s: rdata=%h hit=%b expected rdata=%h hit=%b", e.name, rdata_o, hit_o, e.rdata, e.hit);
    end
  endtask

  task automatic test_async_reset();
    logic [4:0] offs [5] = '{TMR_CTRL, TMR_PRESCALE, TMR_COMPARE, TMR_COUNT, TMR_STATUS};
    bus_write(TMR_CTRL, 32'h0);
    bus_write(TMR_STATUS, 32'h1);
    bus_write(TMR_COMPARE, 32'h0);
    bus_write(TMR_COUNT, 32'h0);
    bus_write(TMR_CTRL, 32'h7);
    step(2);
    sb.push_back('{32'h7, 1'b1, "arst_ctrl_before"});
    bus_read(TMR_CTRL);
    e = sb.pop_front();
    checks++;
    if (rdata_o !== e.rdata || hit_o !== e.hit || irq_o !== 1'b1) begin
      errors++;
      $display("FAIL %s: rdata=%h hit=%b irq=%b expected rdata=%h hit=%b irq=1",
               e.name, rdata_o, hit_o, irq_o, e.rdata, e.hit);
    end
    #2;
    reset_i = 1'b1;
    #1;
    checks++;
    if (irq_o !== 1'b0 || rdata_o !== 32'h0 || hit_o !== 1'b0) begin
      errors++;
      $display("FAIL arst_no_edge: rdata=%h hit=%b irq=%b expected 0/0/0", rdata_o, hit_o, irq_o);
    end
    step(2);
    reset_i = 1'b0;
    for (int i = 0; i < 5; i++) begin
      sb.push_back('{32'h0, 1'b1, $sformatf("arst_rd_off%0h", offs[i])});
      bus_read(offs[i]);
      e = sb.pop_front();
      checks++;
      if (rdata_o !== e.rdata || hit_o !== e.hit) begin
        errors++;
        $display("FAIL %s: rdata=%h hit=%b expected rdata=%h hit=%b", e.name, rdata_o, hit_o, e.rdata, e.hit);
      end
    end
  endtask

  initial begin
    test_reset();
    test_periodic();
    test_oneshot();
    test_wrap();
    test_simultaneous();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
